// File: rtl/gonso_color_fifo.sv
// rtl/gonso_color_fifo.sv - color sample FIFO drained over Wishbone
// Captures 8-bit color samples; DATA/STATUS/CTRL registers plus threshold interrupt.
module gonso_color_fifo #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h30030010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [31:0] wishbone_address,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic [7:0]  color_i,
  input  logic        color_valid_i,
  output logic        irq_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovf, en;
  logic [7:0]    thresh;

  logic req, hit_data, hit_stat, hit_ctrl;
  logic full, empty, pop_now, push_try, push_now, ovf_event, flush_now, ovf_clr;
  logic [31:0] rd_data;
  logic unused_ok;

  assign req      = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign hit_data = (wishbone_address == BASE_ADDR);
  assign hit_stat = (wishbone_address == BASE_ADDR + 32'd4);
  assign hit_ctrl = (wishbone_address == BASE_ADDR + 32'd8);

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  assign pop_now   = req && !wbs_we_i && hit_data && !empty;
  assign flush_now = req && wbs_we_i && hit_ctrl && wbs_sel_i[1] && wbs_dat_i[9];
  assign ovf_clr   = req && wbs_we_i && hit_stat && wbs_sel_i[2] && wbs_dat_i[16];
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_try  = color_valid_i && en && !flush_now;
  assign push_now  = push_try && (!full || pop_now);
  assign ovf_event = push_try && full && !pop_now;

  assign irq_o = en && (thresh != 8'd0) &&
                 ({{(9-CW){1'b0}}, count} >= {1'b0, thresh});

  assign unused_ok = ^{wbs_sel_i[3], wbs_dat_i[31:17], wbs_dat_i[15:10]};

  always_comb begin
    rd_data = 32'd0;
    if (!wbs_we_i) begin
      if (hit_data && !empty)
        rd_data = {23'd0, 1'b1, mem[rptr]};
      else if (hit_stat)
        rd_data = {15'd0, ovf, 6'd0, empty, full, 8'(count)};
      else if (hit_ctrl)
        rd_data = {23'd0, en, thresh};
    end
  end

  always_ff @(posedge clk) begin
    if (push_now)
      mem[wptr] <= color_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      en        <= 1'b0;
      thresh    <= 8'd1;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= req;
      if (req)
        wbs_dat_o <= rd_data;

      if (flush_now) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push_now) wptr <= wptr + AW'(1);
        if (pop_now)  rptr <= rptr + AW'(1);
        if (push_now && !pop_now)      count <= count + CW'(1);
        else if (pop_now && !push_now) count <= count - CW'(1);
      end

      if (ovf_event)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      if (req && wbs_we_i && hit_ctrl) begin
        if (wbs_sel_i[0]) thresh <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) en     <= wbs_dat_i[8];
      end
    end
  end
endmodule

// File: doc/gonso_color_fifo.md
# gonso_color_fifo

Downstream stage of the Honzales color path: captures each 8-bit color result sample into a DEPTH-entry FIFO and lets the management core drain it over Wishbone. It occupies the address window directly above the existing gonso registers (0x30030010–0x30030018) and raises a level interrupt when a programmable fill threshold is reached. Overflow is recorded in a sticky flag.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..128.
- BASE_ADDR, 32'h30030010: byte address of DATA; STATUS = BASE_ADDR+4, CTRL = BASE_ADDR+8.
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_stb_i  input  1  Wishbone strobe.
- wishbone_address  input  32  byte address; exact-match decode.
- wbs_we_i  input  1  1 write, 0 read.
- wbs_dat_i  input  32  write data.
- wbs_sel_i  input  4  byte lane selects.
- wbs_dat_o  output  32  registered read data.
- wbs_ack_o  output  1  registered acknowledge.
- color_i  input  8  color sample from the Honzales core.
- color_valid_i  input  1  color_i qualifier, one sample per high cycle.
- irq_o  output  1  level interrupt, fill threshold reached.

## Operation
- Storage: DEPTH×8 array, read/write pointers of clog2(DEPTH) bits wrapping modulo DEPTH, count of clog2(DEPTH)+1 bits (0..DEPTH). full = (count==DEPTH), empty = (count==0).
- Push: color_valid_i && en && !flush_now && (!full || pop_now) writes color_i at wptr, wptr+1. Push attempted while full with no same-cycle pop: sample dropped, ovf set. en=0: samples ignored, ovf unaffected.
- Request: req = wbs_cyc_i && wbs_stb_i && !wbs_ack_o. Each req gets exactly one ack.
- DATA read (we=0): non-empty → dat_o = {23'b0, 1'b1, head}, pop (rptr+1). Empty → dat_o = 0, no pop. DATA writes are acked and ignored.
- STATUS read: [7:0] count, [8] full, [9] empty, [16] ovf, others 0. STATUS write: sel[2] && dat_i[16] clears ovf (W1C); a same-cycle overflow event wins (ovf stays 1).
- CTRL read: [7:0] thresh, [8] en, others 0 (flush reads 0). CTRL write: sel[0] loads thresh = dat_i[7:0]; sel[1] loads en = dat_i[8]; sel[1] && dat_i[9] asserts flush_now for that cycle.
- Flush: pointers and count to 0, contents don't-care; beats a same-cycle push (sample dropped, ovf unchanged).
- Unmapped address: acked, dat_o = 0, no side effects.
- Count update per cycle: +1 push only, −1 pop only, unchanged for both or neither.
- irq_o = en && (thresh != 0) && (count >= thresh), from registered state only; thresh > DEPTH never fires.

## Timing
- Reset (rst_n low, immediate): wbs_ack_o=0, wbs_dat_o=0, irq_o=0, count=0, pointers=0, ovf=0, thresh=8'd1, en=0.
- Wishbone: req sampled at edge N; ack and dat_o valid in cycle N+1; ack deasserts at N+2 regardless of stb. Back-to-back requests therefore take 2 cycles each. wbs_dat_o holds its value until the next ack.
- Pop, CTRL/STATUS updates and flush take effect at edge N; STATUS read at N returns pre-edge values.
- Push: sample at edge M visible in count/irq_o during cycle M+1; readable via DATA by a req at M+1 (ack M+2).
- Simultaneous push+pop when full: both succeed, count stays DEPTH, ovf unchanged. Push+pop-attempt when empty: push succeeds, read returns 0 (no bypass).
- Reset mid-transaction: ack drops at once; the interrupted request is not acked after release.

## Test plan
- Reset: hold rst_n low 3 cycles → ack=0, dat_o=0, irq_o=0; STATUS read = 0x00000200; CTRL read = 0x00000001.
- Capture/drain: CTRL write 0x00000103 (en, thresh 3); push 0x11,0x22,0x33 → irq_o=1 cycle after third push; three DATA reads → 0x111, 0x122, 0x133; irq_o=0 after first read; fourth read → 0x0.
- Overflow: en=1, push 9 samples (DEPTH=8) → STATUS = 0x00010108; drain returns first 8 only; STATUS write 0x00010000 sel=4'b0100 → ovf cleared.
- Simultaneous: fill to 8, then DATA read at the same edge as a push of 0xAA → count stays 8, ovf=0, 0xAA is the 8th value returned.
- Flush and wrap: push 5, read 5, push 6 (pointer wrap) → data in order; CTRL write 0x00000301 with push same cycle → count 0, ovf 0, en=1.
- Misc: read 0x3003001C → ack, dat 0; assert rst_n low during an acked cycle → ack falls immediately, no extra ack after release.
